// File: rtl/uc_pkg.sv
// Shared definitions for the stack-machine control unit: opcodes, FSM states, instruction fields.
package uc_pkg;

  localparam int unsigned INSTR_W = 21;
  localparam int unsigned OPC_W   = 5;
  localparam int unsigned IMM_W   = 16;
  localparam int unsigned OPC_MSB = 20;
  localparam int unsigned OPC_LSB = 16;
  localparam int unsigned IMM_MSB = 15;
  localparam int unsigned IMM_LSB = 0;

  localparam logic [OPC_W-1:0] OP_NOP   = 5'b00000;
  localparam logic [OPC_W-1:0] OP_PUSHI = 5'b00001;
  localparam logic [OPC_W-1:0] OP_POP   = 5'b00010;
  localparam logic [OPC_W-1:0] OP_ADD   = 5'b00100;
  localparam logic [OPC_W-1:0] OP_SUB   = 5'b00101;
  localparam logic [OPC_W-1:0] OP_AND   = 5'b00110;
  localparam logic [OPC_W-1:0] OP_OR    = 5'b00111;
  localparam logic [OPC_W-1:0] OP_XOR   = 5'b01000;
  localparam logic [OPC_W-1:0] OP_SHL   = 5'b01001;
  localparam logic [OPC_W-1:0] OP_SHR   = 5'b01010;
  localparam logic [OPC_W-1:0] OP_NOT   = 5'b01011;
  localparam logic [OPC_W-1:0] OP_JMP   = 5'b01100;
  localparam logic [OPC_W-1:0] OP_JZ    = 5'b01101;
  localparam logic [OPC_W-1:0] OP_HALT  = 5'b11111;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    PUSH   = 3'd2,
    POP1   = 3'd3,
    POP2   = 3'd4,
    EXEC   = 3'd5,
    BRANCH = 3'd6,
    HALT   = 3'd7
  } state_e;

  // Two-operand ULA operations occupy a contiguous opcode range.
  function automatic logic is_binary(input logic [OPC_W-1:0] op);
    return (op >= OP_ADD) && (op <= OP_SHR);
  endfunction

  // Number of stack entries an instruction consumes before it can run.
  function automatic logic [1:0] operands_needed(input logic [OPC_W-1:0] op);
    logic [1:0] n;
    n = 2'd0;
    if (is_binary(op)) begin
      n = 2'd2;
    end else if ((op == OP_NOT) || (op == OP_POP) || (op == OP_JZ)) begin
      n = 2'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/uc_depth_ctr.sv
// Stack-depth tracker: follows the issued push/pop strobes and flags full/underflow for decode.
module uc_depth_ctr #(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc_i,
  input  logic       dec_i,
  input  logic [1:0] need_i,
  output logic       full_c_o,
  output logic       underflow_c_o
);

  logic [CNT_W-1:0] depth_q;

  // Up/down counter; a simultaneous push and pop leaves the depth unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      depth_q <= '0;
    end else if (inc_i && !dec_i) begin
      depth_q <= depth_q + CNT_W'(1);
    end else if (dec_i && !inc_i) begin
      depth_q <= depth_q - CNT_W'(1);
    end
  end

  assign full_c_o      = (depth_q == CNT_W'(DEPTH));
  assign underflow_c_o = (depth_q < CNT_W'(need_i));

endmodule

// File: rtl/unidade_controle.sv
// Control unit: fetches from a registered ROM, decodes and sequences the stack datapath strobes.
module unidade_controle
  import uc_pkg::*;
#(
  parameter int unsigned PC_W   = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DATA_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [INSTR_W-1:0]   instr,
  input  logic [DATA_W-1:0]    tos,
  output logic [PC_W-1:0]      pc,
  output logic [DATA_W-1:0]    din_UC,
  output logic [OPC_W-1:0]     opcode,
  output logic                 wren,
  output logic                 controle_pilha,
  output logic                 pilha_en,
  output logic                 load_temp1,
  output logic                 load_temp2,
  output logic                 halted,
  output logic                 erro
);

  state_e              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [INSTR_W-1:0]  ir_q, ir_d;
  logic                zero_q, zero_d;
  logic [DATA_W-1:0]   din_q, din_d;
  logic [OPC_W-1:0]    opc_q, opc_d;
  logic                wren_q, wren_d;
  logic                cp_q, cp_d;
  logic                pe_q, pe_d;
  logic                lt1_q, lt1_d;
  logic                lt2_q, lt2_d;
  logic                halted_q, halted_d;
  logic                erro_q, erro_d;

  logic [OPC_W-1:0]    instr_opc;
  logic [OPC_W-1:0]    ir_opc;
  logic [PC_W-1:0]     pc_inc;
  logic [1:0]          need_c;
  logic                full_c;
  logic                underflow_c;

  assign instr_opc = instr[OPC_MSB:OPC_LSB];
  assign ir_opc    = ir_q[OPC_MSB:OPC_LSB];
  assign pc_inc    = pc_q + PC_W'(1);
  assign need_c    = operands_needed(instr_opc);

  // Depth follows the strobes actually issued, so it is settled by the next DECODE.
  uc_depth_ctr #(
    .DEPTH(DEPTH)
  ) u_depth (
    .clk          (clk),
    .rst          (reset),
    .inc_i        (pe_q && wren_q),
    .dec_i        (pe_q && !wren_q),
    .need_i       (need_c),
    .full_c_o     (full_c),
    .underflow_c_o(underflow_c)
  );

  // State, program counter, IR and registered datapath controls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= FETCH;
      pc_q     <= '0;
      ir_q     <= '0;
      zero_q   <= 1'b0;
      din_q    <= '0;
      opc_q    <= '0;
      wren_q   <= 1'b0;
      cp_q     <= 1'b0;
      pe_q     <= 1'b0;
      lt1_q    <= 1'b0;
      lt2_q    <= 1'b0;
      halted_q <= 1'b0;
      erro_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      zero_q   <= zero_d;
      din_q    <= din_d;
      opc_q    <= opc_d;
      wren_q   <= wren_d;
      cp_q     <= cp_d;
      pe_q     <= pe_d;
      lt1_q    <= lt1_d;
      lt2_q    <= lt2_d;
      halted_q <= halted_d;
      erro_q   <= erro_d;
    end
  end

  // Next state; strobes are computed for the state being entered so they appear registered in it.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    zero_d   = zero_q;
    din_d    = '0;
    opc_d    = '0;
    wren_d   = 1'b0;
    cp_d     = 1'b0;
    pe_d     = 1'b0;
    lt1_d    = 1'b0;
    lt2_d    = 1'b0;
    halted_d = halted_q;
    erro_d   = erro_q;

    case (state_q)
      FETCH: begin
        state_d = DECODE;
      end

      DECODE: begin
        ir_d   = instr;
        zero_d = (tos == '0);
        if (underflow_c || ((instr_opc == OP_PUSHI) && full_c)) begin
          state_d  = HALT;
          halted_d = 1'b1;
          erro_d   = 1'b1;
        end else if (is_binary(instr_opc) || (instr_opc == OP_NOT)) begin
          state_d = POP1;
          pe_d    = 1'b1;
          lt1_d   = 1'b1;
          lt2_d   = (instr_opc == OP_NOT);
          opc_d   = instr_opc;
        end else begin
          case (instr_opc)
            OP_PUSHI: begin
              state_d = PUSH;
              pe_d    = 1'b1;
              wren_d  = 1'b1;
              din_d   = DATA_W'(instr[IMM_MSB:IMM_LSB]);
            end
            OP_POP: begin
              state_d = POP1;
              pe_d    = 1'b1;
            end
            OP_JMP: begin
              pc_d    = PC_W'(instr[IMM_MSB:IMM_LSB]);
              state_d = FETCH;
            end
            OP_JZ: begin
              state_d = BRANCH;
              pe_d    = 1'b1;
            end
            OP_HALT: begin
              state_d  = HALT;
              halted_d = 1'b1;
            end
            default: begin
              pc_d    = pc_inc;
              state_d = FETCH;
            end
          endcase
        end
      end

      PUSH: begin
        pc_d    = pc_inc;
        state_d = FETCH;
      end

      POP1: begin
        if (ir_opc == OP_POP) begin
          pc_d    = pc_inc;
          state_d = FETCH;
        end else if (ir_opc == OP_NOT) begin
          state_d = EXEC;
          pe_d    = 1'b1;
          wren_d  = 1'b1;
          cp_d    = 1'b1;
          opc_d   = ir_opc;
        end else begin
          state_d = POP2;
          pe_d    = 1'b1;
          lt2_d   = 1'b1;
          opc_d   = ir_opc;
        end
      end

      POP2: begin
        state_d = EXEC;
        pe_d    = 1'b1;
        wren_d  = 1'b1;
        cp_d    = 1'b1;
        opc_d   = ir_opc;
      end

      EXEC: begin
        pc_d    = pc_inc;
        state_d = FETCH;
      end

      BRANCH: begin
        pc_d    = zero_q ? PC_W'(ir_q[IMM_MSB:IMM_LSB]) : pc_inc;
        state_d = FETCH;
      end

      HALT: begin
        state_d = HALT;
      end

      default: begin
        state_d = FETCH;
      end
    endcase
  end

  assign pc             = pc_q;
  assign din_UC         = din_q;
  assign opcode         = opc_q;
  assign wren           = wren_q;
  assign controle_pilha = cp_q;
  assign pilha_en       = pe_q;
  assign load_temp1     = lt1_q;
  assign load_temp2     = lt2_q;
  assign halted         = halted_q;
  assign erro           = erro_q;

endmodule

// File: tb/tb_unidade_controle.sv
// Bench for unidade_controle: instruction-level reference trace, directed table, reset corner, random programs.
module tb_unidade_controle;

  localparam int unsigned PC_W   = 8;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned DATA_W = 16;
  localparam int          SDEPTH = 8;

  localparam logic [4:0] O_NOP = 5'd0,  O_PUSHI = 5'd1,  O_POP = 5'd2,  O_ADD = 5'd4;
  localparam logic [4:0] O_SUB = 5'd5,  O_AND = 5'd6,    O_OR = 5'd7,   O_XOR = 5'd8;
  localparam logic [4:0] O_SHL = 5'd9,  O_SHR = 5'd10,   O_NOT = 5'd11, O_JMP = 5'd12;
  localparam logic [4:0] O_JZ  = 5'd13, O_HALT = 5'd31;

  typedef struct {
    logic [7:0]  pc;
    logic [15:0] din;
    logic [4:0]  op;
    logic        wren, cp, pe, lt1, lt2, hlt, err;
    bit          chk_din, chk_op;
  } cyc_t;

  typedef struct {
    logic [20:0] w [6];
    int          far_a;
    logic [20:0] far_w;
    int          ncyc;
    int          e_pc;
    logic        e_hlt;
    logic        e_err;
    int          e_depth;
    int          e_push;
  } vec_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [20:0]       instr = '0;
  logic [DATA_W-1:0] tos;
  logic [PC_W-1:0]   pc;
  logic [DATA_W-1:0] din_UC;
  logic [4:0]        opcode;
  logic              wren, controle_pilha, pilha_en, load_temp1, load_temp2, halted, erro;

  logic [20:0]       rom [256];
  logic [15:0]       smem [SDEPTH];
  int                sp = 0;
  logic [15:0]       t1 = '0, t2 = '0;
  cyc_t              exp_q [$];
  vec_t              tbl [8];
  int                total = 0, bad = 0;

  unidade_controle #(.PC_W(PC_W), .DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .instr(instr), .tos(tos), .pc(pc), .din_UC(din_UC),
    .opcode(opcode), .wren(wren), .controle_pilha(controle_pilha), .pilha_en(pilha_en),
    .load_temp1(load_temp1), .load_temp2(load_temp2), .halted(halted), .erro(erro));

  always #5 clk = ~clk;

  // Registered ROM, one cycle of read latency.
  always @(posedge clk) instr <= rom[pc];

  function automatic logic [15:0] alu(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      O_ADD:   return b + a;
      O_SUB:   return b - a;
      O_AND:   return b & a;
      O_OR:    return b | a;
      O_XOR:   return b ^ a;
      O_SHL:   return b << a[3:0];
      O_SHR:   return b >> a[3:0];
      O_NOT:   return ~a;
      default: return 16'h0;
    endcase
  endfunction

  // Datapath stand-in: a value stack and temp registers obeying the DUT's strobes.
  always_comb tos = (sp > 0 && sp <= SDEPTH) ? smem[sp-1] : 16'h0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      sp <= 0;
    end else begin
      if (load_temp1) t1 <= tos;
      if (load_temp2) t2 <= tos;
      if (pilha_en) begin
        if (wren) begin
          if (sp < SDEPTH) begin
            smem[sp] <= controle_pilha ? alu(opcode, t1, t2) : din_UC;
            sp <= sp + 1;
          end
        end else if (sp > 0) begin
          sp <= sp - 1;
        end
      end
    end
  end

  function automatic logic [20:0] ins(input logic [4:0] op, input logic [15:0] imm);
    return {op, imm};
  endfunction

  function automatic cyc_t mk(input int p);
    cyc_t c;
    c.pc = 8'(p); c.din = 16'h0; c.op = 5'h0;
    c.wren = 0; c.cp = 0; c.pe = 0; c.lt1 = 0; c.lt2 = 0; c.hlt = 0; c.err = 0;
    c.chk_din = 0; c.chk_op = 0;
    return c;
  endfunction

  // Instruction-level reference: executes the ROM and lists the expected outputs of every cycle.
  task automatic build_trace(input int ncyc);
    int p, need;
    bit hlt, er;
    logic [15:0] stk [$];
    logic [20:0] w;
    logic [4:0] op;
    logic [15:0] imm, a, b;
    cyc_t c;
    p = 0; hlt = 0; er = 0;
    exp_q.delete();
    while (exp_q.size() < ncyc) begin
      if (hlt) begin
        c = mk(p); c.hlt = 1; c.err = er; exp_q.push_back(c);
        continue;
      end
      w = rom[p]; op = w[20:16]; imm = w[15:0];
      exp_q.push_back(mk(p));
      exp_q.push_back(mk(p));
      need = (op >= O_ADD && op <= O_SHR) ? 2 : (op == O_NOT || op == O_POP || op == O_JZ) ? 1 : 0;
      if (stk.size() < need || (op == O_PUSHI && stk.size() == DEPTH)) begin
        hlt = 1; er = 1;
        continue;
      end
      if (need == 2) begin
        c = mk(p); c.pe = 1; c.lt1 = 1; exp_q.push_back(c);
        c = mk(p); c.pe = 1; c.lt2 = 1; exp_q.push_back(c);
        c = mk(p); c.pe = 1; c.wren = 1; c.cp = 1; c.op = op; c.chk_op = 1; exp_q.push_back(c);
        a = stk.pop_back(); b = stk.pop_back(); stk.push_back(alu(op, a, b));
        p = (p + 1) % 256;
      end else begin
        case (op)
          O_PUSHI: begin
            c = mk(p); c.pe = 1; c.wren = 1; c.din = imm; c.chk_din = 1; exp_q.push_back(c);
            stk.push_back(imm); p = (p + 1) % 256;
          end
          O_POP: begin
            c = mk(p); c.pe = 1; exp_q.push_back(c);
            void'(stk.pop_back()); p = (p + 1) % 256;
          end
          O_NOT: begin
            c = mk(p); c.pe = 1; c.lt1 = 1; c.lt2 = 1; exp_q.push_back(c);
            c = mk(p); c.pe = 1; c.wren = 1; c.cp = 1; c.op = op; c.chk_op = 1; exp_q.push_back(c);
            a = stk.pop_back(); stk.push_back(~a); p = (p + 1) % 256;
          end
          O_JMP: p = int'(imm[7:0]);
          O_JZ: begin
            a = stk.pop_back();
            c = mk(p); c.pe = 1; exp_q.push_back(c);
            p = (a == 16'h0) ? int'(imm[7:0]) : (p + 1) % 256;
          end
          O_HALT: hlt = 1;
          default: p = (p + 1) % 256;
        endcase
      end
    end
    while (exp_q.size() > ncyc) void'(exp_q.pop_back());
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, want);
    end
  endtask

  task automatic cmp_cycle(input int i, input cyc_t e);
    logic [35:0] av, ev;
    ev = {e.pc, e.chk_din ? e.din : 16'h0, e.chk_op ? e.op : 5'h0,
          e.wren, e.cp, e.pe, e.lt1, e.lt2, e.hlt, e.err};
    av = {pc, e.chk_din ? din_UC : 16'h0, e.chk_op ? opcode : 5'h0,
          wren, controle_pilha, pilha_en, load_temp1, load_temp2, halted, erro};
    check($sformatf("cyc%0d", i), 64'(av), 64'(ev));
  endtask

  // Caller sits just after a negedge with reset released; compares one expected entry per cycle.
  task automatic cmp_trace(input int ncyc, output int pushes);
    pushes = 0;
    for (int i = 0; i < ncyc; i++) begin
      if (i > 0) @(negedge clk);
      cmp_cycle(i, exp_q[i]);
      if (pilha_en === 1'b1 && wren === 1'b1) pushes++;
    end
  endtask

  task automatic start_prog();
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("reset_state", 64'({pc, din_UC, opcode, wren, controle_pilha, pilha_en,
                              load_temp1, load_temp2, halted, erro}), 64'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic load_vec(input vec_t v);
    for (int a = 0; a < 256; a++) rom[a] = ins(O_HALT, 16'h0);
    for (int i = 0; i < 6; i++) rom[i] = v.w[i];
    if (v.far_a >= 0) rom[v.far_a] = v.far_w;
  endtask

  function automatic logic [20:0] rand_ins();
    int r;
    r = int'($urandom_range(0, 99));
    if (r < 30) return ins(O_PUSHI, 16'($urandom_range(0, 3)));
    if (r < 50) return ins(5'(4 + $urandom_range(0, 6)), 16'($urandom));
    if (r < 55) return ins(O_NOT, 16'h0);
    if (r < 63) return ins(O_POP, 16'h0);
    if (r < 68) return ins(O_JMP, 16'($urandom_range(0, 255)));
    if (r < 78) return ins(O_JZ, 16'($urandom_range(0, 255)));
    if (r < 84) return ins(O_NOP, 16'h0);
    if (r < 88) return ins(O_HALT, 16'h0);
    if (r < 92) return ins(5'd3, 16'h0);
    return ins(5'($urandom_range(14, 30)), 16'($urandom));
  endfunction

  initial begin
    int pushes;
    logic [20:0] H;
    H = ins(O_HALT, 16'h0);
    for (int a = 0; a < 256; a++) rom[a] = H;

    tbl[0] = '{'{ins(O_PUSHI,16'h1234), ins(O_PUSHI,16'h0001), ins(O_ADD,16'h0), H, H, H},
               -1, 21'h0, 20, 3, 1'b1, 1'b0, 1, 3};
    tbl[1] = '{'{ins(O_PUSHI,16'h5), ins(O_ADD,16'h0), H, H, H, H},
               -1, 21'h0, 12, 1, 1'b1, 1'b1, 1, 1};
    tbl[2] = '{'{ins(O_PUSHI,16'h1), ins(O_PUSHI,16'h2), ins(O_PUSHI,16'h3), ins(O_PUSHI,16'h4),
                 ins(O_PUSHI,16'h5), H},
               -1, 21'h0, 20, 4, 1'b1, 1'b1, 4, 4};
    tbl[3] = '{'{ins(O_PUSHI,16'h0), ins(O_JZ,16'h10), H, H, H, H},
               -1, 21'h0, 14, 16, 1'b1, 1'b0, 0, 1};
    tbl[4] = '{'{ins(O_PUSHI,16'h5), ins(O_JZ,16'h10), H, H, H, H},
               -1, 21'h0, 14, 2, 1'b1, 1'b0, 0, 1};
    tbl[5] = '{'{ins(O_JMP,16'hFF), H, H, H, H, H},
               255, ins(O_NOP,16'h0), 5, 0, 1'b0, 1'b0, 0, 0};
    tbl[6] = '{'{ins(O_PUSHI,16'h0), ins(O_NOT,16'h0), ins(O_JZ,16'h20), H, H, H},
               -1, 21'h0, 20, 3, 1'b1, 1'b0, 0, 2};
    tbl[7] = '{'{ins(O_PUSHI,16'h3), ins(O_PUSHI,16'h3), ins(O_SUB,16'h0), ins(O_JZ,16'h30), H, H},
               -1, 21'h0, 26, 48, 1'b1, 1'b0, 0, 3};

    // Directed programs: cycle-by-cycle trace plus hand-derived end state.
    for (int t = 0; t < 8; t++) begin
      load_vec(tbl[t]);
      build_trace(tbl[t].ncyc);
      start_prog();
      cmp_trace(tbl[t].ncyc, pushes);
      check($sformatf("t%0d_pc", t), 64'(pc), 64'(tbl[t].e_pc));
      check($sformatf("t%0d_halted", t), 64'(halted), 64'(tbl[t].e_hlt));
      check($sformatf("t%0d_erro", t), 64'(erro), 64'(tbl[t].e_err));
      check($sformatf("t%0d_depth", t), 64'(sp), 64'(tbl[t].e_depth));
      check($sformatf("t%0d_pushes", t), 64'(pushes), 64'(tbl[t].e_push));
    end

    // Reset in POP2 of an ADD: strobes drop at once, then a fresh run sees an empty stack.
    load_vec(tbl[0]);
    build_trace(10);
    start_prog();
    cmp_trace(10, pushes);
    check("pop2_strobes", 64'({pilha_en, load_temp1, load_temp2}), 64'(3'b101));
    #1;
    reset = 1'b1;
    #1;
    check("async_drop", 64'({pilha_en, load_temp1, load_temp2, wren, controle_pilha, opcode}), 64'h0);
    check("async_pc", 64'(pc), 64'h0);
    load_vec(tbl[2]);
    build_trace(tbl[2].ncyc);
    @(negedge clk);
    reset = 1'b0;
    #1;
    cmp_trace(tbl[2].ncyc, pushes);
    check("rst_pushes", 64'(pushes), 64'd4);
    check("rst_erro", 64'(erro), 64'd1);

    // Random programs against the reference trace.
    for (int r = 0; r < 20; r++) begin
      for (int a = 0; a < 256; a++) rom[a] = rand_ins();
      build_trace(150);
      start_prog();
      cmp_trace(150, pushes);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/unidade_controle.md
Name: unidade_controle

Overview:
- Control unit that drives the stack datapath (stack, temp1/temp2 registers, ULA) from a program stored in an external instruction ROM.
- Fetches and decodes 21-bit instructions and sequences the datapath strobes: wren, controle_pilha, stack write/pop enable, load_temp1, load_temp2, opcode, din_UC.
- Tracks stack depth to detect overflow and underflow. Handles jumps and halt.

Parameters:
- PC_W, 8, program counter / ROM address width.
- DEPTH, 16, datapath stack capacity in words; used for the overflow check.
- DATA_W, 16, datapath word width (din_UC, tos).

Ports:
- clk  in  1  single system clock. All datapath enables are synchronous to it.
- reset  in  1  asynchronous, active-high.
- instr  in  21  ROM data; registered ROM with 1-cycle read latency. Bits [20:16] opcode, [15:0] immediate.
- tos  in  DATA_W  datapath top of stack.
- pc  out  PC_W  ROM address.
- din_UC  out  DATA_W  immediate pushed onto the stack.
- opcode  out  5  ULA operation select.
- wren  out  1  1 = stack push, 0 = stack pop (qualified by pilha_en).
- controle_pilha  out  1  stack input select: 0 = din_UC, 1 = ULA result.
- pilha_en  out  1  one-cycle stack operation strobe.
- load_temp1  out  1  one-cycle temp1 capture strobe.
- load_temp2  out  1  one-cycle temp2 capture strobe.
- halted  out  1  sticky; set by HALT or by an error.
- erro  out  1  sticky stack overflow/underflow flag.

Behaviour:
- Reset (asynchronous): pc=0, state=FETCH, depth=0, IR=0. All strobes, wren, controle_pilha, opcode, din_UC, halted and erro are 0. Outputs are registered.
- Opcode map:
  - 00000 NOP
  - 00001 PUSHI
  - 00010 POP
  - 00100–01010 binary ULA ops (ADD, SUB, AND, OR, XOR, SHL, SHR)
  - 01011 NOT (unary)
  - 01100 JMP
  - 01101 JZ
  - 11111 HALT
  - Any other value executes as NOP.
- FETCH: present pc. Next state is DECODE, where instr is valid and latched into IR.
- DECODE (checks and actions):
  - Underflow check: a binary op with depth<2, or NOT/POP/JZ with depth<1, sets erro and halted and enters HALT.
  - Overflow check: PUSHI with depth==DEPTH does the same.
  - NOP/unknown: pc+1, go to FETCH.
  - JMP: pc=imm[PC_W-1:0], go to FETCH.
  - HALT: halted=1, enter HALT.
- PUSHI: one cycle with din_UC=imm, wren=1, controle_pilha=0, pilha_en=1. depth+1, pc+1. Total 3 cycles.
- POP: one cycle with wren=0, pilha_en=1. depth-1, pc+1.
- Binary op:
  - POP1: pop with load_temp1=1.
  - POP2: pop with load_temp2=1.
  - EXEC: opcode=IR opcode, controle_pilha=1, wren=1, pilha_en=1.
  - Net depth -1. 5 cycles total.
  - opcode holds its value through EXEC; controle_pilha returns to 0 after EXEC.
- NOT: POP1 asserts load_temp1 and load_temp2 together, then EXEC. Net depth 0.
- JZ: tos is sampled in DECODE. The stack is popped in the next cycle. If the sampled tos==0, pc=imm; otherwise pc+1.
- HALT: absorbing state. All strobes are 0. Exited only by reset.
- Strobe rules:
  - pilha_en, load_temp1 and load_temp2 are never high for more than one consecutive cycle per state.
  - pilha_en is never asserted in FETCH or DECODE.
- pc wraps modulo 2^PC_W.
- Reset mid-instruction: all strobes drop immediately (asynchronously). depth is cleared.

Decomposition:
- Shared package uc_pkg holds:
  - opcode constants (OP_NOP, OP_PUSHI, OP_POP, OP_ADD…OP_SHR, OP_NOT, OP_JMP, OP_JZ, OP_HALT);
  - the state enum (FETCH, DECODE, PUSH, POP1, POP2, EXEC, BRANCH, HALT);
  - instruction field slice constants.
- One natural sub-module: uc_depth_ctr. It is the stack-depth up/down counter with full/empty and underflow-need comparison, which keeps the FSM readable.

Test Plan:
- PUSHI 0x1234; PUSHI 0x0001; ADD; HALT:
  - pilha_en with wren=1, din_UC=0x1234 at cycle 3, and with din_UC=0x0001 at cycle 6.
  - load_temp1 then load_temp2 on consecutive cycles.
  - EXEC cycle: opcode=00100, controle_pilha=1.
  - Final depth 1, halted=1, erro=0.
- ADD with depth 1: erro=1 and halted=1 after DECODE. No strobes issued. pc frozen.
- DEPTH=4 with 5× PUSHI: exactly 4 push strobes, then erro=1 at the fifth DECODE.
- PUSHI 0; JZ 0x10: pop strobe issued, next pc=0x10. With PUSHI 5 instead, next pc is the JZ address+1.
- JMP 0xFF with PC_W=8, then NOP at 0xFF: pc wraps to 0x00.
- Assert reset during POP2 of an ADD: all strobes go low in the same cycle. After release, pc=0 and depth=0, and the program restarts from FETCH.
